// File: rtl/xs3_serial_adder.sv
// xs3_serial_adder: digit-serial excess-3 decimal adder, LSD first, one digit pair per handshake.
// Optional feature macro: XS3_ERR_CHECK_EN (enables err_xs3 invalid-code detection; otherwise tied 0).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start / busy             begin an addition (IDLE only) / high in RUN or DONE
//   a_xs3, b_xs3, in_valid   operand digit pair and its valid
//   in_ready                 high only in RUN
//   sum_xs3, sum_idx         registered excess-3 sum digit and its index
//   out_valid, done          per-digit pulse / pulse with the last digit
//   carry_out                final decimal carry, held until the next start
//   err_xs3                  invalid-code flag pulsing with out_valid
module xs3_serial_adder #(
  parameter int DIGITS = 4,
  localparam int CW = $clog2(DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  input  logic [3:0]    a_xs3,
  input  logic [3:0]    b_xs3,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [3:0]    sum_xs3,
  output logic [CW-1:0] sum_idx,
  output logic          out_valid,
  output logic          done,
  output logic          carry_out,
  output logic          err_xs3
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic carry_q, carry_d, cout_q, cout_d, ov_q, ov_d;
  logic [CW-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [3:0] sum_q, sum_d;
  logic [4:0] s;
  logic xfer, last;
  assign xfer = state_q == RUN && in_valid;
  assign last = cnt_q == CW'(DIGITS - 1);
  // Excess-3 sums carry a +6 bias: a binary carry means a decimal carry (re-add 3), else remove 3.
  assign s = {1'b0, a_xs3} + {1'b0, b_xs3} + {4'b0, carry_q};
  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ov_d    = xfer;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        carry_d = 1'b0;
        cnt_d   = '0;
        cout_d  = 1'b0;
      end
      RUN: if (in_valid) begin
        sum_d   = s[4] ? s[3:0] + 4'd3 : s[3:0] - 4'd3;
        carry_d = s[4];
        idx_d   = cnt_q;
        cnt_d   = cnt_q + CW'(1);
        state_d = last ? DONE : RUN;
        cout_d  = last ? s[4] : cout_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= 4'b0011;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ov_q    <= ov_d;
    end
  end
`ifdef XS3_ERR_CHECK_EN
  logic err_q, err_d;
  assign err_d = xfer && (a_xs3 < 4'd3 || a_xs3 > 4'd12 || b_xs3 < 4'd3 || b_xs3 > 4'd12);
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err_xs3 = err_q;
`else
  assign err_xs3 = 1'b0;
`endif
  assign busy      = state_q != IDLE;
  assign in_ready  = state_q == RUN;
  assign done      = state_q == DONE;
  assign sum_xs3   = sum_q;
  assign sum_idx   = idx_q;
  assign out_valid = ov_q;
  assign carry_out = cout_q;
endmodule

// File: tb/tb_xs3_serial_adder.sv
// tb_xs3_serial_adder: random decimal additions checked against an integer-arithmetic reference.
module tb_xs3_serial_adder;
  localparam int DIGITS = 4;
  logic clk = 0, rst = 0, start = 0, in_valid = 0;
  logic [3:0] a_xs3 = 0, b_xs3 = 0;
  logic busy, in_ready, out_valid, done, carry_out, err_xs3;
  logic [3:0] sum_xs3;
  logic [1:0] sum_idx;
  int nvec = 0, nerr = 0;
  int pw[DIGITS];

  xs3_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .a_xs3(a_xs3), .b_xs3(b_xs3), .in_valid(in_valid), .in_ready(in_ready),
    .sum_xs3(sum_xs3), .sum_idx(sum_idx), .out_valid(out_valid), .done(done),
    .carry_out(carry_out), .err_xs3(err_xs3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_err", err_xs3, 0);
    chk("rst_sum", sum_xs3, 3);
    chk("rst_idx", sum_idx, 0);
  endtask

  // Adds decimal a+b; bad forces digit 0 of A to the invalid code 0000 (sums then not checked).
  // abort_after >= 0 stops feeding after that digit and returns without finishing.
  task automatic run_add(input int a, input int b, input int max_stall, input bit bad, input int abort_after);
    int tot, k;
    tot = a + b;
    start = 1;
    tick();
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_ready", in_ready, 1);
    for (int d = 0; d < DIGITS; d++) begin
      k = (max_stall > 0) ? $urandom_range(max_stall, 0) : 0;
      repeat (k) begin
        tick();
        chk("stall_ov", out_valid, 0);
        chk("stall_ready", in_ready, 1);
      end
      a_xs3 = (bad && d == 0) ? 4'd0 : 4'((a / pw[d]) % 10 + 3);
      b_xs3 = 4'((b / pw[d]) % 10 + 3);
      in_valid = 1;
      tick();
      in_valid = 0;
      a_xs3 = 4'($urandom);
      b_xs3 = 4'($urandom);
      chk("ov", out_valid, 1);
      chk("idx", sum_idx, d);
      if (!bad) chk("sum", sum_xs3, (tot / pw[d]) % 10 + 3);
`ifdef XS3_ERR_CHECK_EN
      chk("err", err_xs3, (bad && d == 0) ? 1 : 0);
`else
      chk("err", err_xs3, 0);
`endif
      chk("done", done, d == DIGITS - 1 ? 1 : 0);
      if (d == abort_after) return;
    end
    if (!bad) chk("carry", carry_out, tot >= 10000 ? 1 : 0);
    chk("done_ready", in_ready, 0);
    in_valid = 1;
    tick();
    in_valid = 0;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ov", out_valid, 0);
    if (!bad) chk("carry_hold", carry_out, tot >= 10000 ? 1 : 0);
    tick();
    chk("idle_ov2", out_valid, 0);
  endtask

  initial begin
    pw[0] = 1;
    for (int i = 1; i < DIGITS; i++) pw[i] = pw[i-1] * 10;
    rst = 1;
    tick();
    tick();
    chk_reset_state();
    rst = 0;
    tick();
    start = 0;
    in_valid = 1;
    tick();
    in_valid = 0;
    chk("idle_ignore_valid", out_valid, 0);
    run_add(25, 17, 0, 0, -1);
    run_add(9999, 1, 0, 0, -1);
    run_add(25, 17, 3, 0, -1);
    run_add(9999, 1, 0, 0, 1);
    rst = 1;
    start = 1;
    tick();
    rst = 0;
    start = 0;
    chk_reset_state();
    run_add(25, 17, 0, 0, -1);
    run_add(9999, 9999, 0, 0, -1);
    run_add(0, 0, 0, 0, -1);
    for (int n = 0; n < 40; n++)
      run_add($urandom_range(9999, 0), $urandom_range(9999, 0), 2, 0, -1);
    run_add(123, 456, 0, 1, -1);
    run_add(5000, 5000, 0, 0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
